aes_key_sched: RTL

- Iterative, parametrised AES key schedule supporting AES-128, AES-192 and AES-256, selected per run.
- Generates one 32-bit schedule word per clock and stores all words in internal registers.
- Exposes the stored round keys through a random-access read port.
- Sits between the UART command/key loader and the AES round datapath. It is the sequential successor of the combinational AES-128-only key expansion.

---
 rtl/aes_key_sched.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched -- iterative AES-128/192/256 key schedule.
//
// Produces one 32-bit schedule word per clock into an internal register file
// and serves the stored round keys through a combinational read port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request expansion, honoured only while ready=1
//   key_len           00=128, 01=192, 10=256, 11=reserved
//   key_in            cipher key, big-endian, shorter keys left-aligned
//   ready             idle, able to accept start
//   done              one-cycle pulse when the schedule is complete
//   key_valid         a complete schedule is stored
//   err               one-cycle pulse after a start with an illegal key_len
//   num_rounds        Nr of the stored schedule (0 after reset)
//   rk_idx / rk_out   round-key read index / {w[4i], w[4i+1], w[4i+2], w[4i+3]}
//   rk_dec_out        (AES_KS_INV_EN only) round key for the equivalent
//                     inverse cipher: InvMixColumns(rk_out) for inner rounds
//
// Build option: define AES_KS_INV_EN to add rk_dec_out.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // entry a sits (255-a) bytes above the LSB
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_key_sched #(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  ready,
  output logic                  done,
  output logic                  key_valid,
  output logic                  err,
  output logic [3:0]            num_rounds,
  input  logic [IDX_W-1:0]      rk_idx,
`ifdef AES_KS_INV_EN
  output logic [127:0]          rk_dec_out,
`endif
  output logic [127:0]          rk_out
);
  localparam int TW = 4*(MAX_NR+1);
  localparam int IW = $clog2(TW);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]   w [TW];
  logic [3:0]    nk, nr, sel_nk, sel_nr;
  logic [IW-1:0] wi, ip, ik;
  logic [2:0]    wm;          // wi mod nk, kept incrementally
  logic [7:0]    rcon;
  logic          sel_ok, accept, reject, last;
  logic [31:0]   prev, sub_in, sub_out, temp, wnew;

  // key_len decode; lengths beyond MAX_NK are rejected like the reserved code
  always_comb begin
    sel_nk = 4'd4;
    sel_nr = 4'd10;
    case (key_len)
      2'b01: begin sel_nk = 4'd6; sel_nr = 4'd12; end
      2'b10: begin sel_nk = 4'd8; sel_nr = 4'd14; end
      default: ;
    endcase
    sel_ok = (key_len != 2'b11) && (32'(sel_nk) <= MAX_NK);
  end

  assign accept = start && (state == IDLE) && sel_ok;
  assign reject = start && (state == IDLE) && !sel_ok;

  // expansion datapath
  assign ip     = wi - IW'(1);
  assign ik     = wi - IW'(nk);
  assign prev   = w[ip];
  assign sub_in = (wm == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  always_comb begin
    temp = prev;
    if (wm == 3'd0)                       temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && wm == 3'd4)    temp = sub_out;
  end

  assign wnew = w[ik] ^ temp;
  assign last = (wi == IW'({nr, 2'b11}));   // T-1 = 4*Nr+3

  // FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   begin ready = 1'b1; if (accept) state_nx = LOAD; end
      LOAD:   state_nx = EXPAND;
      EXPAND: if (last) state_nx = DONE;
      DONE:   begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nk <= '0; nr <= '0; wi <= '0; wm <= '0; rcon <= '0;
      key_valid <= 1'b0; num_rounds <= '0; err <= 1'b0;
    end else begin
      err <= reject;
      case (state)
        IDLE: if (accept) begin
          nk <= sel_nk; nr <= sel_nr; key_valid <= 1'b0;
        end
        LOAD: begin
          wi <= IW'(nk); wm <= '0; rcon <= 8'h01;
        end
        EXPAND: begin
          wi <= wi + IW'(1);
          wm <= ({1'b0, wm} == nk - 4'd1) ? 3'd0 : wm + 3'd1;
          if (wm == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (last) begin key_valid <= 1'b1; num_rounds <= nr; end
        end
        default: ;
      endcase
    end

  // schedule storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < TW; k++) w[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < MAX_NK; k++)
        if (4'(k) < nk) w[k] <= key_in[32*(MAX_NK-k)-1 -: 32];
    end else if (state == EXPAND) begin
      w[wi] <= wnew;
    end

  // read port; zero unless a complete schedule holds that round
  always_comb begin
    rk_out = '0;
    for (int q = 0; q < 4; q++) begin
      logic [IDX_W+1:0] ra;
      ra = {rk_idx, 2'(q)};
      if (key_valid && 32'(rk_idx) <= 32'(num_rounds) && 32'(ra) < TW)
        rk_out[127-32*q -: 32] = w[IW'(ra)];
    end
  end

`ifdef AES_KS_INV_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2, m4, m8;
    logic [7:0] e [4], b [4], d [4], n [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      m2 = xt(a[i]); m4 = xt(m2); m8 = xt(m4);
      e[i] = m8 ^ m4 ^ m2;  b[i] = m8 ^ m2 ^ a[i];
      d[i] = m8 ^ m4 ^ a[i]; n[i] = m8 ^ a[i];
    end
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = e[i] ^ b[(i+1)%4] ^ d[(i+2)%4] ^ n[(i+3)%4];
    return r;
  endfunction

  // first and last round keys pass through; an all-zero rk_out maps to zero
  always_comb begin
    rk_dec_out = rk_out;
    if (32'(rk_idx) != 0 && 32'(rk_idx) != 32'(num_rounds))
      for (int q = 0; q < 4; q++)
        rk_dec_out[127-32*q -: 32] = imc_col(rk_out[127-32*q -: 32]);
  end
`endif

endmodule
